// File: rtl/nav_fsm_multi_if.sv
// Button/heading bundle for nav_fsm_multi; centre button and PAUSED exist only with NAV_PAUSE_EN.
// Latency: none, wiring only.
// Backpressure: none, level and strobe signals only.
interface nav_fsm_multi_if #(
    parameter int N_PLAYERS = 1
);
    logic                   TICK;
    logic [N_PLAYERS-1:0]   BTNU;
    logic [N_PLAYERS-1:0]   BTNR;
    logic [N_PLAYERS-1:0]   BTND;
    logic [N_PLAYERS-1:0]   BTNL;
    logic [2*N_PLAYERS-1:0] NSM_state;
    logic [N_PLAYERS-1:0]   DIR_CHG;
`ifdef NAV_PAUSE_EN
    logic                   BTNC;
    logic                   PAUSED;

    modport master (output TICK, BTNU, BTNR, BTND, BTNL, BTNC,
                    input  NSM_state, DIR_CHG, PAUSED);
    modport slave  (input  TICK, BTNU, BTNR, BTND, BTNL, BTNC,
                    output NSM_state, DIR_CHG, PAUSED);
`else
    modport master (output TICK, BTNU, BTNR, BTND, BTNL,
                    input  NSM_state, DIR_CHG);
    modport slave  (input  TICK, BTNU, BTNR, BTND, BTNL,
                    output NSM_state, DIR_CHG);
`endif
endinterface

// File: rtl/nav_fsm_multi.sv
// Multi-player snake heading FSM: debounced buttons, reverse-turn block, heading committed on TICK (NAV_PAUSE_EN adds pause).
// Latency: raw button -> pending in 2+DEBOUNCE_CYCLES+1 cycles; TICK -> NSM_state/DIR_CHG next cycle.
// Backpressure: none; presses are judged immediately, invalid ones dropped, last valid press per move wins.
module nav_fsm_multi #(
    parameter int         N_PLAYERS       = 1,
    parameter int         DEBOUNCE_CYCLES = 250000,
    parameter logic [1:0] RESET_DIR       = 2'd1
) (
    input  logic          CLK,
    input  logic          RESET,
    nav_fsm_multi_if.slave bus
);
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam int NDIR = 4 * N_PLAYERS;
`ifdef NAV_PAUSE_EN
    localparam int NB = NDIR + 1;
`else
    localparam int NB = NDIR;
`endif
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] db;
    logic [NB-1:0] db_d;
    logic [NB-1:0] press;
    logic [CW-1:0] cnt [NB];

    // Per player the four buttons sit at [4p+3:4p] ordered U,R,D,L.
    always_comb begin
        raw = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            raw[4*p+0] = bus.BTNU[p];
            raw[4*p+1] = bus.BTNR[p];
            raw[4*p+2] = bus.BTND[p];
            raw[4*p+3] = bus.BTNL[p];
        end
`ifdef NAV_PAUSE_EN
        raw[NDIR] = bus.BTNC;
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_d  <= db;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = db & ~db_d;

    logic paused;
    logic unpause;

`ifdef NAV_PAUSE_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) paused <= 1'b0;
        else if (press[NDIR]) paused <= ~paused;
    end
    assign unpause    = paused & press[NDIR];
    assign bus.PAUSED = paused;
`else
    assign paused  = 1'b0;
    assign unpause = 1'b0;
`endif

    logic                 tick_eff;
    logic [1:0]           cur     [N_PLAYERS];
    logic [1:0]           pend    [N_PLAYERS];
    logic [1:0]           cand    [N_PLAYERS];
    logic [1:0]           ref_dir [N_PLAYERS];
    logic [N_PLAYERS-1:0] accept;
    logic [N_PLAYERS-1:0] chg;

    assign tick_eff = bus.TICK & ~paused;

    // On a TICK cycle the pending value becomes committed, so judge against it.
    always_comb begin
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (press[4*p+0])      cand[p] = DIR_UP;
            else if (press[4*p+1]) cand[p] = DIR_RIGHT;
            else if (press[4*p+2]) cand[p] = DIR_DOWN;
            else                   cand[p] = DIR_LEFT;
            ref_dir[p] = tick_eff ? pend[p] : cur[p];
            accept[p]  = (|press[4*p +: 4]) && !paused &&
                         (cand[p] != ref_dir[p]) &&
                         (cand[p] != (ref_dir[p] ^ 2'b10));
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            chg <= '0;
            for (int p = 0; p < N_PLAYERS; p++) begin
                cur[p]  <= RESET_DIR;
                pend[p] <= RESET_DIR;
            end
        end else begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                chg[p] <= tick_eff && (pend[p] != cur[p]);
                if (tick_eff) cur[p] <= pend[p];
                if (accept[p])     pend[p] <= cand[p];
                else if (unpause)  pend[p] <= cur[p];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_PLAYERS; g++) begin : g_out
            assign bus.NSM_state[2*g +: 2] = cur[g];
        end
    endgenerate
    assign bus.DIR_CHG = chg;

endmodule

// File: tb/tb_nav_fsm_multi.sv
// Directed bench for nav_fsm_multi: 2 players, 4-cycle debounce, reset heading RIGHT.
// Inputs change 1ns after the rising edge; outputs are checked at the same offset.
module tb_nav_fsm_multi;
    logic CLK = 1'b0;
    logic RESET;
    int   n_chk  = 0;
    int   n_pass = 0;

    nav_fsm_multi_if #(.N_PLAYERS(2)) bus ();

    nav_fsm_multi #(
        .N_PLAYERS(2),
        .DEBOUNCE_CYCLES(4),
        .RESET_DIR(2'b01)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // which: 0=U 1=R 2=D 3=L
    task automatic set_btn(input int which, input int p, input logic v);
        case (which)
            0: bus.BTNU[p] = v;
            1: bus.BTNR[p] = v;
            2: bus.BTND[p] = v;
            default: bus.BTNL[p] = v;
        endcase
    endtask

    task automatic press_btn(input int which, input int p);
        set_btn(which, p, 1'b1);
        step(8);
        set_btn(which, p, 1'b0);
        step(8);
    endtask

    task automatic do_tick;
        bus.TICK = 1'b1;
        step(1);
        bus.TICK = 1'b0;
    endtask

    // Raise a button so its press pulse coincides with a TICK.
    task automatic press_on_tick(input int which, input int p);
        set_btn(which, p, 1'b1);
        step(6);
        bus.TICK = 1'b1;
        step(1);
        bus.TICK = 1'b0;
    endtask

    initial begin
        RESET    = 1'b1;
        bus.TICK = 1'b0;
        bus.BTNU = '0;
        bus.BTNR = '0;
        bus.BTND = '0;
        bus.BTNL = '0;
`ifdef NAV_PAUSE_EN
        bus.BTNC = 1'b0;
`endif
        step(3);
        RESET = 1'b0;
        step(1);
        check("reset_state", bus.NSM_state, 4'b0101);
        check("reset_chg", bus.DIR_CHG, 2'b00);

        // bounce: 2-cycle toggles never survive 4-cycle debounce
        for (int i = 0; i < 10; i++) begin
            bus.BTNU[0] = ~bus.BTNU[0];
            step(2);
        end
        bus.BTNU[0] = 1'b0;
        step(10);
        do_tick();
        check("bounce_state", bus.NSM_state, 4'b0101);
        check("bounce_chg", bus.DIR_CHG, 2'b00);

        press_btn(0, 0);
        check("pend_not_yet_committed", bus.NSM_state, 4'b0101);
        do_tick();
        check("up_state", bus.NSM_state, 4'b0100);
        check("up_chg", bus.DIR_CHG, 2'b01);
        step(1);
        check("up_chg_one_cycle", bus.DIR_CHG, 2'b00);

        press_btn(1, 0);
        do_tick();
        check("right_state", bus.NSM_state, 4'b0101);
        check("right_chg", bus.DIR_CHG, 2'b01);

        press_btn(3, 0);
        do_tick();
        check("reverse_state", bus.NSM_state, 4'b0101);
        check("reverse_chg", bus.DIR_CHG, 2'b00);

        press_btn(2, 0);
        press_btn(0, 0);
        do_tick();
        check("last_wins_state", bus.NSM_state, 4'b0100);
        check("last_wins_chg", bus.DIR_CHG, 2'b01);
        press_btn(1, 0);
        do_tick();
        check("restore_p0_right", bus.NSM_state, 4'b0101);

        // simultaneous U and D on player 1: U has priority
        bus.BTNU[1] = 1'b1;
        bus.BTND[1] = 1'b1;
        step(8);
        bus.BTNU[1] = 1'b0;
        bus.BTND[1] = 1'b0;
        step(8);
        do_tick();
        check("simul_state", bus.NSM_state, 4'b0001);
        check("simul_chg", bus.DIR_CHG, 2'b10);
        press_btn(1, 1);
        do_tick();
        check("restore_p1_right", bus.NSM_state, 4'b0101);

        // P=UP, C=RIGHT, DOWN lands on TICK: dropped as reverse of UP
        press_btn(0, 0);
        press_on_tick(2, 0);
        check("tick_down_state", bus.NSM_state, 4'b0100);
        check("tick_down_chg", bus.DIR_CHG, 2'b01);
        bus.BTND[0] = 1'b0;
        step(8);
        do_tick();
        check("tick_down_dropped", bus.NSM_state, 4'b0100);
        check("tick_down_dropped_chg", bus.DIR_CHG, 2'b00);

        press_btn(1, 0);
        do_tick();
        check("restore_p0_right2", bus.NSM_state, 4'b0101);
        press_btn(0, 0);
        press_on_tick(3, 0);
        check("tick_left_state", bus.NSM_state, 4'b0100);
        bus.BTNL[0] = 1'b0;
        step(8);
        do_tick();
        check("tick_left_commit", bus.NSM_state, 4'b0111);
        check("tick_left_chg", bus.DIR_CHG, 2'b01);

        // async reset right after a commit and with a press mid-debounce
        press_btn(0, 1);
        do_tick();
        check("pre_reset_state", bus.NSM_state, 4'b0011);
        check("pre_reset_chg", bus.DIR_CHG, 2'b10);
        bus.BTNL[1] = 1'b1;
        step(3);
        #2 RESET = 1'b1;
        #1;
        check("async_reset_state", bus.NSM_state, 4'b0101);
        check("async_reset_chg", bus.DIR_CHG, 2'b00);
        bus.BTNL[1] = 1'b0;
        step(2);
        RESET = 1'b0;
        step(10);
        do_tick();
        check("post_reset_state", bus.NSM_state, 4'b0101);
        check("post_reset_chg", bus.DIR_CHG, 2'b00);

`ifdef NAV_PAUSE_EN
        check("pause_reset", bus.PAUSED, 1'b0);
        bus.BTNC = 1'b1;
        step(8);
        bus.BTNC = 1'b0;
        step(8);
        check("paused_on", bus.PAUSED, 1'b1);
        press_btn(0, 0);
        for (int t = 0; t < 3; t++) begin
            do_tick();
            check("paused_state", bus.NSM_state, 4'b0101);
            check("paused_chg", bus.DIR_CHG, 2'b00);
        end
        bus.BTNC = 1'b1;
        step(8);
        bus.BTNC = 1'b0;
        step(8);
        check("paused_off", bus.PAUSED, 1'b0);
        do_tick();
        check("unpause_state", bus.NSM_state, 4'b0101);
        check("unpause_chg", bus.DIR_CHG, 2'b00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/nav_fsm_multi.md
Name: nav_fsm_multi

Overview:
- Parametrised successor to the single-player snake navigation state machine.
- Serves N_PLAYERS players, each with four raw push-buttons (up/right/down/left).
- Per button: synchronises and debounces the input, then detects the press edge.
- Keeps a 2-bit heading per player. Reverse turns are forbidden; turns are buffered and committed only on a game move TICK, so two quick presses within one move cannot reverse the snake.

Parameters:
- N_PLAYERS, 1, number of independent button groups / heading registers (1..4).
- DEBOUNCE_CYCLES, 250000, stable-level cycles required before a debounced button changes (>=2).
- RESET_DIR, 2'd1, heading loaded at reset (encoding below; default RIGHT).

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RESET  in  1  asynchronous, active-high reset; clears all state immediately.
- TICK  in  1  one-cycle move strobe from the game timer; commits pending headings.
- BTNU  in  N_PLAYERS  raw up buttons, bit p = player p.
- BTNR  in  N_PLAYERS  raw right buttons.
- BTND  in  N_PLAYERS  raw down buttons.
- BTNL  in  N_PLAYERS  raw left buttons.
- NSM_state  out  2*N_PLAYERS  committed heading; bits [2p+1:2p] = player p.
- DIR_CHG  out  N_PLAYERS  one-cycle pulse when player p's committed heading changes.

Behaviour:
- Encoding: 00=UP, 01=RIGHT, 10=DOWN, 11=LEFT. Reverse of d is d XOR 2'b10.
- Reset values (asynchronous):
  - NSM_state = RESET_DIR replicated per player; pending = RESET_DIR.
  - DIR_CHG = 0; synchronisers, debounced levels and counters = 0.
- Input path, per raw bit:
  - 2-FF synchroniser, then a counter of width clog2(DEBOUNCE_CYCLES).
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Press = debounced rising edge, one cycle. Release edges are ignored.
  - Latency raw->press: 2 sync cycles + DEBOUNCE_CYCLES cycles.
- Request select, per player per cycle:
  - Several presses in the same cycle: priority U > R > D > L; one candidate only.
- Acceptance, per player, two registers: committed C (drives NSM_state) and pending P.
  - Reference value R = C on ordinary cycles; R = P on TICK cycles (P is being committed that cycle).
  - Candidate accepted if it is != R and != reverse(R). Accepted candidate -> P.
  - Same-heading or reverse candidates are dropped silently.
  - Later accepted presses before a TICK overwrite P: last valid press wins.
- Commit, on TICK:
  - C <= P. DIR_CHG[p] = 1 in the following cycle iff the new C differs from the old C.
  - A press in the TICK cycle is judged against the just-committed value and lands in P for the next TICK.
  - TICK held high on consecutive cycles: each cycle is treated as a separate commit.
- Players are fully independent; no shared state.
- RESET asserted mid-debounce or mid-pending: all progress discarded, outputs return to reset values in the same cycle. First valid press needs a full debounce after release.

Optional Feature:
- Macro NAV_PAUSE_EN.
- Defined:
  - Adds input BTNC (1 bit, raw centre button) and output PAUSED (1 bit, reset 0).
  - BTNC passes through the same sync/debounce path; each press toggles PAUSED.
  - While PAUSED=1: TICK is ignored and all direction presses are dropped (P unchanged, DIR_CHG stays 0). Debounce counters keep running.
  - On unpause, pending values are cleared back to the current committed heading.
- Undefined: no BTNC/PAUSED ports and no pause logic.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, N_PLAYERS=2, RESET_DIR=01.)
- Reset: hold RESET 3 cycles, release -> NSM_state=4'b0101, DIR_CHG=00. Assert RESET asynchronously mid-run -> outputs return to these values before the next clock edge.
- Bounce filter:
  - BTNU[0] toggled every 2 cycles for 20 cycles, then held low -> no press; P and C stay 01.
  - BTNU[0] held high 8 cycles, then one TICK -> NSM_state[1:0]=00; DIR_CHG=01 for exactly one cycle.
- Reverse block: C=RIGHT, press LEFT, TICK -> heading stays 01, DIR_CHG=0.
  - Press DOWN, then UP before the TICK -> TICK commits UP (00), since UP is judged against C=RIGHT.
- Simultaneous: from C=RIGHT, press BTNU[1] and BTND[1] in the same cycle, then TICK -> player 1 heading=00. Player 0 unchanged at 01.
- Press coincident with TICK: P=UP, C=RIGHT; DOWN press lands on the TICK cycle -> C=UP and DOWN dropped (reverse of UP). A LEFT press in the same position instead -> C=UP, then LEFT (11) committed on the next TICK.
- NAV_PAUSE_EN: press BTNC -> PAUSED=1; UP press plus 3 TICKs -> heading unchanged, DIR_CHG=0. Press BTNC again -> PAUSED=0; next TICK produces no change.
